hci_core_mux_static_ctrl: RTL
=============================

Name: hci_core_mux_static_ctrl

Overview:
Ownership scheduler for an HCI static multiplexer. Requesters (engines, DMA, cores) ask for exclusive ownership of the shared HCI initiator port, and the block drives the mux select accordingly. It tracks outstanding reads on the muxed port and changes the select only when the port is quiescent, so strictly alternative use is enforced in hardware.

Parameters:
NB_CHAN, 2, number of requesters; equals mux channel count.
MAX_OUTSTANDING, 8, maximum in-flight reads tracked; counter width CNT_W = $clog2(MAX_OUTSTANDING+1).
WATCHDOG_CYCLES, 1024, ownership timeout (optional feature only).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous clear; same effect as reset
own_req_i  in  NB_CHAN  per-requester ownership request (level)
release_i  in  NB_CHAN  per-requester release pulse; only the owner's bit is honoured
own_gnt_o  out  NB_CHAN  one-hot ownership grant (level)
sel_o  out  $clog2(NB_CHAN-1)+1  mux select
mon_req_i  in  1  muxed port req
mon_gnt_i  in  1  muxed port gnt
mon_wen_i  in  1  muxed port wen (1 = read)
mon_r_valid_i  in  1  muxed port r_valid
mon_r_ready_i  in  1  muxed port r_ready
busy_o  out  1  FSM not in IDLE
err_o  out  1  sticky protocol error

Behaviour:
- Reset/clear: state IDLE, sel_o=0, own_gnt_o=0, outstanding=0, rr pointer=0, busy_o=0, err_o=0.
- FSM states: IDLE, OWNED, DRAIN.
- IDLE: if any own_req_i is set, pick a winner round-robin, starting from the rr pointer (index after the last winner). Same edge: sel_o<=winner, own_gnt_o<=onehot(winner), state->OWNED, rr pointer<=winner+1 mod NB_CHAN. Grant latency is 1 cycle from the request. If no request, sel_o holds its last value.
- OWNED: sel_o is frozen. On release_i[owner] -> DRAIN and own_gnt_o<=0 on the same edge. Dropping own_req_i alone does not release. release_i from a non-owner is ignored.
- DRAIN: wait until outstanding==0 and mon_req_i==0, then -> IDLE. Arbitration is possible on the following cycle, so a new owner is granted no earlier than 2 cycles after drain completes.
- Outstanding counter:
  - +1 on mon_req_i & mon_gnt_i & mon_wen_i.
  - −1 on mon_r_valid_i & mon_r_ready_i.
  - Simultaneous increment and decrement leaves it unchanged.
  - Writes are not counted.
  - The counter runs in all states.
- Saturation/underflow: increment at MAX_OUTSTANDING, or decrement at 0 without a simultaneous increment, sets err_o (sticky until reset/clear) and leaves the counter unchanged.
- Simultaneous release_i and a new own_req_i from the same requester: the release wins; the request is re-arbitrated after DRAIN.
- clear_i mid-operation: immediate return to the reset values, with no drain.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: HCI_MUX_STATIC_CTRL_WATCHDOG_EN.
- When defined:
  - A cycle counter resets on entry to OWNED and counts while in OWNED.
  - On reaching WATCHDOG_CYCLES with another requester's own_req_i pending, the block forces OWNED->DRAIN as if the owner had released, and sets err_o.
  - The counter resets on any mon_req_i & mon_gnt_i handshake, so an active owner is never pre-empted.
- When undefined: no counter is instantiated and ownership ends only on release_i.

Decomposition:
- Shared package hci_package gains:
  - the FSM enum hci_mux_ctrl_state_e (IDLE, OWNED, DRAIN);
  - the constant for the select-width helper.
- One natural sub-module: hci_rr_arbiter (NB_CHAN-wide round-robin arbiter). Inputs: request vector and enable. Outputs: one-hot grant and index; it updates its pointer on enable&|req.
- The outstanding counter stays inline.

Test Plan:
- Reset, then own_req_i=2'b10 -> cycle+1: own_gnt_o=2'b10, sel_o=1, busy_o=1.
- Owner 0 issues 3 granted reads, then release_i[0]. With r_valid returned after 5 cycles -> state stays DRAIN until the third r_valid&r_ready; sel_o is unchanged throughout; IDLE the cycle after.
- own_req_i=2'b11 persistent with immediate release each ownership -> grants alternate 0,1,0,1; no requester is granted twice in a row.
- Drive mon_r_valid_i&mon_r_ready_i with outstanding=0 -> err_o=1 next cycle and stays 1; counter stays 0.
- clear_i asserted in DRAIN with outstanding=2 -> next cycle: state IDLE, outstanding=0, own_gnt_o=0, sel_o=0, err_o=0.
- With HCI_MUX_STATIC_CTRL_WATCHDOG_EN, WATCHDOG_CYCLES=16: owner 0 idle, requester 1 pending -> at cycle 16 own_gnt_o=0 and err_o=1, then grant to 1 two cycles after DRAIN exits.

Source files
------------

// File: rtl/hci_core_mux_static_ctrl_pkg.sv
// hci_core_mux_static_ctrl_pkg: shared FSM type and select-width helper for the static mux controller
package hci_core_mux_static_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, OWNED, DRAIN} hci_mux_ctrl_state_e;

    function automatic int unsigned sel_w(input int unsigned n);
        return $clog2(n - 1) + 1;
    endfunction

endpackage

// File: rtl/hci_core_mux_static_ctrl_if.sv
// hci_core_mux_static_ctrl_if: ownership handshake and muxed-port monitor bundle
interface hci_core_mux_static_ctrl_if
    import hci_core_mux_static_ctrl_pkg::*;
#(
    parameter int unsigned NB_CHAN = 2,
    parameter int unsigned SEL_W   = sel_w(NB_CHAN)
);
    logic [NB_CHAN-1:0] own_req_i;
    logic [NB_CHAN-1:0] release_i;
    logic [NB_CHAN-1:0] own_gnt_o;
    logic [SEL_W-1:0]   sel_o;
    logic               mon_req_i;
    logic               mon_gnt_i;
    logic               mon_wen_i;
    logic               mon_r_valid_i;
    logic               mon_r_ready_i;
    logic               busy_o;
    logic               err_o;

    modport master (
        output own_req_i, release_i, mon_req_i, mon_gnt_i, mon_wen_i, mon_r_valid_i, mon_r_ready_i,
        input  own_gnt_o, sel_o, busy_o, err_o
    );

    modport slave (
        input  own_req_i, release_i, mon_req_i, mon_gnt_i, mon_wen_i, mon_r_valid_i, mon_r_ready_i,
        output own_gnt_o, sel_o, busy_o, err_o
    );

endinterface

// File: rtl/hci_core_mux_static_ctrl_rr_arbiter.sv
// hci_core_mux_static_ctrl_rr_arbiter: round-robin pick starting at the slot after the last winner
module hci_core_mux_static_ctrl_rr_arbiter #(
    parameter int unsigned NB_CHAN = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic [NB_CHAN-1:0] req,
    input  logic               en,
    output logic [NB_CHAN-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);
    localparam int unsigned IW = NB_CHAN > 1 ? $clog2(NB_CHAN) : 1;

    logic [IDX_W-1:0] ptr;
    logic             found;
    int               c;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int k = 0; k < int'(NB_CHAN); k++) begin
            c = (int'(ptr) + k) % int'(NB_CHAN);
            if (!found && req[c[IW-1:0]]) begin
                found = 1'b1;
                idx   = IDX_W'(c);
            end
        end
        gnt = found ? NB_CHAN'(1) << idx : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni)
            ptr <= '0;
        else if (clear_i)
            ptr <= '0;
        else if (en && found)
            ptr <= (idx == IDX_W'(NB_CHAN - 1)) ? '0 : idx + 1'b1;

endmodule

// File: rtl/hci_core_mux_static_ctrl.sv
// hci_core_mux_static_ctrl: exclusive-ownership scheduler driving a static HCI mux select.
// Optional ownership watchdog enabled by defining HCI_MUX_STATIC_CTRL_WATCHDOG_EN.
module hci_core_mux_static_ctrl
    import hci_core_mux_static_ctrl_pkg::*;
#(
    parameter int unsigned NB_CHAN         = 2,
    parameter int unsigned MAX_OUTSTANDING = 8
`ifdef HCI_MUX_STATIC_CTRL_WATCHDOG_EN
   ,parameter int unsigned WATCHDOG_CYCLES = 1024
`endif
) (
    input logic                      clk_i,
    input logic                      rst_ni,
    input logic                      clear_i,
    hci_core_mux_static_ctrl_if.slave bus
);
    localparam int unsigned SEL_W = sel_w(NB_CHAN);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    hci_mux_ctrl_state_e state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NB_CHAN-1:0]  arb_gnt;
    logic [SEL_W-1:0]    arb_idx;
    logic                req_any, rel, inc, dec, ovf, udf, wd_fire;

    assign req_any = |bus.own_req_i;
    assign inc     = bus.mon_req_i & bus.mon_gnt_i & bus.mon_wen_i;
    assign dec     = bus.mon_r_valid_i & bus.mon_r_ready_i;
    assign ovf     = inc & ~dec & (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign udf     = dec & ~inc & (cnt_q == '0);
    assign rel     = (state_q == OWNED) & ((|(bus.release_i & bus.own_gnt_o)) | wd_fire);
    assign cnt_d   = (ovf | udf | (inc ~^ dec)) ? cnt_q : inc ? cnt_q + 1'b1 : cnt_q - 1'b1;
    assign bus.busy_o = state_q != IDLE;

    hci_core_mux_static_ctrl_rr_arbiter #(
        .NB_CHAN (NB_CHAN),
        .IDX_W   (SEL_W)
    ) i_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .req     (bus.own_req_i),
        .en      (state_q == IDLE),
        .gnt     (arb_gnt),
        .idx     (arb_idx)
    );

`ifdef HCI_MUX_STATIC_CTRL_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES);

    logic [WD_W-1:0] wd_q;
    logic            hs;

    // Any accepted request proves the owner is alive, so the timeout restarts.
    assign hs      = bus.mon_req_i & bus.mon_gnt_i;
    assign wd_fire = (state_q == OWNED) & (wd_q == WD_W'(WATCHDOG_CYCLES - 1)) & ~hs &
                     (|(bus.own_req_i & ~bus.own_gnt_o));

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni)
            wd_q <= '0;
        else if (clear_i || state_q != OWNED || hs)
            wd_q <= '0;
        else if (wd_q != WD_W'(WATCHDOG_CYCLES - 1))
            wd_q <= wd_q + 1'b1;
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = req_any ? OWNED : IDLE;
            OWNED:   state_d = rel ? DRAIN : OWNED;
            DRAIN:   state_d = (cnt_q == '0 && !bus.mon_req_i) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bus.err_o     <= 1'b0;
            bus.sel_o     <= '0;
            bus.own_gnt_o <= '0;
        end else if (clear_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bus.err_o     <= 1'b0;
            bus.sel_o     <= '0;
            bus.own_gnt_o <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus.err_o <= bus.err_o | ovf | udf | wd_fire;
            if (state_q == IDLE && req_any) begin
                bus.sel_o     <= arb_idx;
                bus.own_gnt_o <= arb_gnt;
            end else if (rel)
                bus.own_gnt_o <= '0;
        end

endmodule
